// File: rtl/cordic_iter_sched.sv
// Iteration scheduler for the expanded hyperbolic CORDIC exponential unit.
// Optional run abort input is enabled by defining CORDIC_SCHED_ABORT_EN.
module cordic_iter_sched #(
  parameter int unsigned D          = 5,
  parameter int unsigned ITER_FIRST = 0,
  parameter int unsigned ITER_LAST  = 31,
  parameter int unsigned NEG_LAST   = 6,
  parameter int unsigned TMO        = 255
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         BEG_FSM,
  input  logic         STAGE_ACK,
  input  logic         DONE_ACK,
`ifdef CORDIC_SCHED_ABORT_EN
  input  logic         ABORT,
`endif
  output logic         EN_ROM,
  output logic [D-1:0] ADRS,
  output logic         LOAD_STAGE,
  output logic         ITER_NEG,
  output logic [D-1:0] ITER_IDX,
  output logic         READY,
  output logic         DONE,
  output logic         ERR
);

  localparam int unsigned     WD_W      = 8;
  localparam logic [D-1:0]    FIRST_IDX = D'(ITER_FIRST);
  localparam logic [D-1:0]    LAST_IDX  = D'(ITER_LAST);
  localparam logic [WD_W-1:0] TMO_CNT   = WD_W'(TMO);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WAIT_ACK,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q;
  logic [D-1:0]    cnt_q;
  logic [D-1:0]    cnt_inc_d;
  logic [WD_W-1:0] wdog_q;
  logic [WD_W-1:0] wdog_d;
  logic            en_rom_q;
  logic [D-1:0]    adrs_q;
  logic            load_stage_q;
  logic            iter_neg_q;
  logic [D-1:0]    iter_idx_q;
  logic            ready_q;
  logic            done_q;
  logic            err_q;

  logic            abort_c;
  logic            to_idle_c;
  logic            is_neg_c;
  logic            last_c;

`ifdef CORDIC_SCHED_ABORT_EN
  assign abort_c = ABORT;
`else
  assign abort_c = 1'b0;
`endif

  assign cnt_inc_d = cnt_q + D'(1);
  assign wdog_d    = wdog_q + WD_W'(1);
  assign is_neg_c  = (32'(cnt_q) <= NEG_LAST);
  assign last_c    = (cnt_q == LAST_IDX);

  // Every way back to IDLE (abort of an active run, or acknowledged DONE/ERR) shares one path.
  assign to_idle_c = (abort_c && (state_q == S_FETCH || state_q == S_LATCH ||
                                  state_q == S_WAIT_ACK))
                  || (DONE_ACK && (state_q == S_DONE || state_q == S_ERR));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= FIRST_IDX;
      wdog_q       <= '0;
      en_rom_q     <= 1'b0;
      adrs_q       <= FIRST_IDX;
      load_stage_q <= 1'b0;
      iter_neg_q   <= 1'b0;
      iter_idx_q   <= FIRST_IDX;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      en_rom_q     <= 1'b0;
      load_stage_q <= 1'b0;
      iter_neg_q   <= 1'b0;
      if (to_idle_c) begin
        state_q    <= S_IDLE;
        cnt_q      <= FIRST_IDX;
        wdog_q     <= '0;
        adrs_q     <= FIRST_IDX;
        iter_idx_q <= FIRST_IDX;
        ready_q    <= 1'b1;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (BEG_FSM) begin
              state_q    <= S_FETCH;
              cnt_q      <= FIRST_IDX;
              adrs_q     <= FIRST_IDX;
              iter_idx_q <= FIRST_IDX;
              en_rom_q   <= 1'b1;
              ready_q    <= 1'b0;
            end
          end
          // ROM data registered during FETCH is valid in LATCH.
          S_FETCH: begin
            state_q      <= S_LATCH;
            load_stage_q <= 1'b1;
            iter_neg_q   <= is_neg_c;
            wdog_q       <= '0;
          end
          S_LATCH: begin
            state_q <= S_WAIT_ACK;
            wdog_q  <= '0;
          end
          // An ack on the cycle the watchdog expires still completes the stage.
          S_WAIT_ACK: begin
            wdog_q <= wdog_d;
            if (STAGE_ACK) begin
              if (last_c) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q    <= S_FETCH;
                cnt_q      <= cnt_inc_d;
                adrs_q     <= cnt_inc_d;
                iter_idx_q <= cnt_inc_d;
                en_rom_q   <= 1'b1;
              end
            end else if (wdog_d == TMO_CNT) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
          S_DONE, S_ERR: begin
          end
          default: begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign EN_ROM     = en_rom_q;
  assign ADRS       = adrs_q;
  assign LOAD_STAGE = load_stage_q;
  assign ITER_NEG   = iter_neg_q;
  assign ITER_IDX   = iter_idx_q;
  assign READY      = ready_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule
